// File: rtl/regio_arbiter_pkg.sv
// Shared definitions for the KSZ8851 register-IO arbiter: engine state codes,
// client indices, arbiter FSM states and the per-client command bundle.
package regio_arbiter_pkg;

  localparam int NUM_CLIENTS = 3;
  localparam int CLIENT_INIT = 0;
  localparam int CLIENT_RECV = 1;
  localparam int CLIENT_XMIT = 2;

  typedef enum logic [3:0] {
    RIO_ADDR0  = 4'd0,
    RIO_ADDR1  = 4'd1,
    RIO_ADDR2  = 4'd2,
    RIO_ADDR3  = 4'd3,
    RIO_WRITE0 = 4'd4,
    RIO_WRITE1 = 4'd5,
    RIO_READ0  = 4'd6,
    RIO_READ1  = 4'd7,
    RIO_DONE   = 4'd8,
    RIO_WAIT   = 4'd9
  } rio_state_e;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_GRANT,
    ARB_DRAIN
  } arb_state_e;

  typedef struct packed {
    logic [7:0]  offset;
    logic        length;
    logic        wr;
    logic [15:0] wdata;
    logic        new_cmd;
    logic        dummy_rd;
  } regio_cmd_t;

endpackage

// File: rtl/regio_arbiter_rr_pick.sv
// Two-way round-robin picker (a = recv, b = xmit) with its registered pointer.
// Pointer favours side a after reset and flips to the loser whenever upd_i is high.
module regio_rr_pick (
  input  logic gclk,
  input  logic grst_n,
  input  logic req_a_i,
  input  logic req_b_i,
  input  logic upd_i,
  output logic pick_b_o
);

  logic favor_b_q, favor_b_d;

  assign pick_b_o  = req_b_i & (~req_a_i | favor_b_q);
  assign favor_b_d = upd_i ? ~pick_b_o : favor_b_q;

  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) favor_b_q <= 1'b0;
    else         favor_b_q <= favor_b_d;
  end

endmodule

// File: rtl/regio_arbiter.sv
// Session arbiter for the shared KSZ8851 register-IO engine (init > recv/xmit RR).
// Optional hold watchdog: define REGIO_ARB_WATCHDOG_EN.
module regio_arbiter
  import regio_arbiter_pkg::*;
#(
  parameter int         MAX_HOLD  = 65535,
  parameter logic [3:0] WAIT_CODE = 4'b1001
) (
  input  logic                               sysclk,
  input  logic                               reset,
  input  logic [NUM_CLIENTS-1:0]             req_i,
  input  logic [NUM_CLIENTS-1:0][7:0]        offset_i,
  input  logic [NUM_CLIENTS-1:0]             length_i,
  input  logic [NUM_CLIENTS-1:0]             WR_i,
  input  logic [NUM_CLIENTS-1:0][15:0]       writeData_i,
  input  logic [NUM_CLIENTS-1:0]             NewCommand_i,
  input  logic [NUM_CLIENTS-1:0]             Dummy_Read_i,
  output logic [NUM_CLIENTS-1:0]             gnt_o,
  output logic [NUM_CLIENTS-1:0][3:0]        state_o,
  output logic [15:0]                        readData_o,
  output logic [7:0]                         offset,
  output logic                               length,
  output logic                               WR,
  output logic [15:0]                        writeData,
  output logic                               NewCommand,
  output logic                               Dummy_Read,
  input  logic [3:0]                         state,
  input  logic [15:0]                        readData,
  output logic                               wdog_err
);

  arb_state_e             st_q, st_d;
  logic [NUM_CLIENTS-1:0] gnt_q, gnt_d;
  logic                   eng_wait, owner_req, hold_hit;
  logic                   pick_xmit, rr_upd;
  regio_cmd_t [NUM_CLIENTS-1:0] cli_cmd;
  regio_cmd_t             eng_cmd;

  assign eng_wait  = (state == WAIT_CODE);
  assign owner_req = |(gnt_q & req_i);

  regio_rr_pick u_rr (
    .gclk     (sysclk),
    .grst_n   (reset),
    .req_a_i  (req_i[CLIENT_RECV]),
    .req_b_i  (req_i[CLIENT_XMIT]),
    .upd_i    (rr_upd),
    .pick_b_o (pick_xmit)
  );

  always_comb begin
    st_d   = st_q;
    gnt_d  = gnt_q;
    rr_upd = 1'b0;
    case (st_q)
      ARB_IDLE: begin
        if (|req_i && eng_wait) begin
          st_d = ARB_GRANT;
          if (req_i[CLIENT_INIT]) begin
            gnt_d = 3'b001;
          end else begin
            gnt_d  = pick_xmit ? 3'b100 : 3'b010;
            rr_upd = 1'b1;
          end
        end
      end
      ARB_GRANT: begin
        // a dropped req only takes effect once the engine is back in Wait
        if (hold_hit || (!owner_req && eng_wait)) begin
          st_d  = ARB_DRAIN;
          gnt_d = '0;
        end
      end
      ARB_DRAIN: begin
        st_d  = ARB_IDLE;
        gnt_d = '0;
      end
      default: begin
        st_d  = ARB_IDLE;
        gnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      st_q  <= ARB_IDLE;
      gnt_q <= '0;
    end else begin
      st_q  <= st_d;
      gnt_q <= gnt_d;
    end
  end

`ifdef REGIO_ARB_WATCHDOG_EN
  logic [15:0] hold_q;
  logic        wdog_q;

  assign hold_hit = (st_q == ARB_GRANT) && (hold_q == 16'(MAX_HOLD - 1));

  // counter sits at zero outside GRANT, so it is cleared on every entry
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      hold_q <= '0;
      wdog_q <= 1'b0;
    end else begin
      hold_q <= (st_q == ARB_GRANT) ? hold_q + 16'd1 : 16'd0;
      wdog_q <= wdog_q | hold_hit;
    end
  end

  assign wdog_err = wdog_q;
`else
  assign hold_hit = 1'b0;
  assign wdog_err = 1'b0;
`endif

  for (genvar c = 0; c < NUM_CLIENTS; c++) begin : g_cli
    assign cli_cmd[c] = '{offset:   offset_i[c],
                          length:   length_i[c],
                          wr:       WR_i[c],
                          wdata:    writeData_i[c],
                          new_cmd:  NewCommand_i[c],
                          dummy_rd: Dummy_Read_i[c]};
    assign state_o[c] = gnt_q[c] ? state : WAIT_CODE;
  end

  always_comb begin
    eng_cmd = '0;
    for (int c = 0; c < NUM_CLIENTS; c++)
      if (gnt_q[c]) eng_cmd = cli_cmd[c];
    if (hold_hit) eng_cmd.new_cmd = 1'b0;
  end

  assign gnt_o      = gnt_q;
  assign readData_o = readData;
  assign offset     = eng_cmd.offset;
  assign length     = eng_cmd.length;
  assign WR         = eng_cmd.wr;
  assign writeData  = eng_cmd.wdata;
  assign NewCommand = eng_cmd.new_cmd;
  assign Dummy_Read = eng_cmd.dummy_rd;

endmodule

// File: tb/tb_regio_arbiter.sv
// Scoreboard bench for regio_arbiter: directed scenarios plus random sessions,
// checked against a session-level reference model.
module tb_regio_arbiter;

  localparam int         HOLD  = 16;
  localparam logic [3:0] WAITC = 4'b1001;
  localparam logic [3:0] READ1 = 4'd7;
  localparam logic [3:0] ADDR0 = 4'd0;

  logic              sysclk, reset;
  logic [2:0]        req_i, length_i, WR_i, NewCommand_i, Dummy_Read_i;
  logic [2:0][7:0]   offset_i;
  logic [2:0][15:0]  writeData_i;
  logic [2:0]        gnt_o;
  logic [2:0][3:0]   state_o;
  logic [15:0]       readData_o, writeData, readData;
  logic [7:0]        offset;
  logic              length, WR, NewCommand, Dummy_Read, wdog_err;
  logic [3:0]        state;

  regio_arbiter #(.MAX_HOLD(HOLD), .WAIT_CODE(WAITC)) dut (
    .sysclk(sysclk), .reset(reset), .req_i(req_i), .offset_i(offset_i),
    .length_i(length_i), .WR_i(WR_i), .writeData_i(writeData_i),
    .NewCommand_i(NewCommand_i), .Dummy_Read_i(Dummy_Read_i), .gnt_o(gnt_o),
    .state_o(state_o), .readData_o(readData_o), .offset(offset), .length(length),
    .WR(WR), .writeData(writeData), .NewCommand(NewCommand), .Dummy_Read(Dummy_Read),
    .state(state), .readData(readData), .wdog_err(wdog_err)
  );

  typedef struct packed {
    logic [2:0]      gnt;
    logic [2:0][3:0] st;
    logic [15:0]     rd;
    logic [7:0]      off;
    logic            len;
    logic            wr;
    logic [15:0]     wd;
    logic            nc;
    logic            dr;
    logic            wdog;
  } exp_t;

  exp_t q[$];
  int   vectors = 0, miscompares = 0;

  // reference model: who owns the engine, whether we are in the post-session gap,
  // which of recv/xmit was served last, and how long the current session has run
  int owner = -1;
  bit gap = 0;
  int last_rr = 2;
  int hold = 0;
  bit wdog = 0;
  bit fix92 = 0;

  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  task automatic step_model();
    exp_t e;
    bit   forced = 0;
    if (!reset) begin
      owner = -1; gap = 0; last_rr = 2; hold = 0; wdog = 0;
    end else if (owner >= 0) begin
`ifdef REGIO_ARB_WATCHDOG_EN
      if (hold == HOLD - 1) forced = 1;
      else hold++;
`endif
      if (forced || (!req_i[owner] && state == WAITC)) begin
        owner = -1; gap = 1;
        if (forced) wdog = 1;
      end
    end else if (gap) begin
      gap = 0;
    end else if (req_i != 3'b000 && state == WAITC) begin
      if (req_i[0])                 owner = 0;
      else if (req_i[1] && req_i[2]) owner = (last_rr == 1) ? 2 : 1;
      else                          owner = req_i[1] ? 1 : 2;
      if (owner != 0) last_rr = owner;
      hold = 0;
    end
    e = '0;
    e.rd   = readData;
    e.wdog = wdog;
    for (int c = 0; c < 3; c++) e.st[c] = (owner == c) ? state : WAITC;
    if (owner >= 0) begin
      e.gnt = 3'(1 << owner);
      e.off = offset_i[owner];
      e.len = length_i[owner];
      e.wr  = WR_i[owner];
      e.wd  = writeData_i[owner];
      e.nc  = NewCommand_i[owner];
      e.dr  = Dummy_Read_i[owner];
`ifdef REGIO_ARB_WATCHDOG_EN
      if (hold == HOLD - 1) e.nc = 1'b0;
`endif
    end
    q.push_back(e);
  endtask

  task automatic cyc(input logic r, input logic [2:0] rq, input logic [3:0] st);
    @(negedge sysclk);
    reset = r;
    req_i = rq;
    state = st;
    for (int c = 0; c < 3; c++) begin
      offset_i[c]     = 8'($urandom);
      length_i[c]     = 1'($urandom);
      WR_i[c]         = 1'($urandom);
      writeData_i[c]  = 16'($urandom);
      NewCommand_i[c] = 1'($urandom);
      Dummy_Read_i[c] = 1'($urandom);
    end
    if (fix92) begin
      offset_i[1]     = 8'h92;
      NewCommand_i[1] = 1'b1;
    end
    readData = 16'($urandom);
    step_model();
  endtask

  initial begin : mon
    exp_t e;
    forever begin
      @(posedge sysclk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("gnt_o",      32'(gnt_o),      32'(e.gnt));
        chk("state_o",    32'(state_o),    32'(e.st));
        chk("readData_o", 32'(readData_o), 32'(e.rd));
        chk("offset",     32'(offset),     32'(e.off));
        chk("length",     32'(length),     32'(e.len));
        chk("WR",         32'(WR),         32'(e.wr));
        chk("writeData",  32'(writeData),  32'(e.wd));
        chk("NewCommand", 32'(NewCommand), 32'(e.nc));
        chk("Dummy_Read", 32'(Dummy_Read), 32'(e.dr));
        chk("wdog_err",   32'(wdog_err),   32'(e.wdog));
      end
    end
  end

  initial begin
    logic [2:0] rq;
    logic [3:0] st;
    reset = 1'b0; req_i = '0; state = WAITC; readData = '0;
    offset_i = '0; length_i = '0; WR_i = '0; writeData_i = '0;
    NewCommand_i = '0; Dummy_Read_i = '0;

    cyc(0, 3'b000, WAITC);
    cyc(0, 3'b011, WAITC);

    // uncontended recv, then reset in the middle of its session
    fix92 = 1;
    cyc(1, 3'b000, WAITC);
    cyc(1, 3'b010, WAITC);
    cyc(1, 3'b010, ADDR0);
    chk("recv_gnt_pre_reset", 32'(gnt_o), 32'h2);
    chk("recv_nc_pre_reset",  32'(NewCommand), 32'h1);
    cyc(0, 3'b010, READ1);
    #1;
    chk("rst_gnt_async",  32'(gnt_o),      32'h0);
    chk("rst_nc_async",   32'(NewCommand), 32'h0);
    chk("rst_wd_async",   32'(writeData),  32'h0);
    fix92 = 0;
    cyc(1, 3'b000, WAITC);

    // init and recv together: init first, recv two edges after init leaves
    cyc(1, 3'b011, WAITC);
    cyc(1, 3'b011, ADDR0);
    cyc(1, 3'b011, WAITC);
    cyc(1, 3'b010, WAITC);
    cyc(1, 3'b010, WAITC);
    cyc(1, 3'b010, WAITC);
    cyc(1, 3'b000, WAITC);
    cyc(1, 3'b000, WAITC);

    // fresh pointer, then recv/xmit alternate across four sessions
    cyc(0, 3'b000, WAITC);
    cyc(1, 3'b000, WAITC);
    for (int s = 0; s < 4; s++) begin
      cyc(1, 3'b110, WAITC);
      cyc(1, 3'b110, WAITC);
      chk("rr_order", 32'(gnt_o), (s % 2 == 0) ? 32'h2 : 32'h4);
      rq = 3'b110;
      if (owner > 0) rq[owner] = 1'b0;
      cyc(1, rq, WAITC);
      cyc(1, 3'b110, WAITC);
    end
    cyc(1, 3'b000, WAITC);
    cyc(1, 3'b000, WAITC);

    // xmit drops req mid-access: grant holds until Wait
    cyc(1, 3'b100, WAITC);
    cyc(1, 3'b100, READ1);
    cyc(1, 3'b000, READ1);
    cyc(1, 3'b000, READ1);
    chk("early_rel_hold", 32'(gnt_o), 32'h4);
    cyc(1, 3'b000, WAITC);
    cyc(1, 3'b000, WAITC);
    cyc(1, 3'b000, WAITC);

`ifdef REGIO_ARB_WATCHDOG_EN
    repeat (40) cyc(1, 3'b110, WAITC);
    cyc(1, 3'b000, WAITC);
    cyc(1, 3'b000, WAITC);
`endif

    rq = '0;
    for (int i = 0; i < 3000; i++) begin
      for (int c = 0; c < 3; c++)
        if ($urandom_range(0, 7) == 0) rq[c] = ~rq[c];
      st = ($urandom_range(0, 1) == 0) ? WAITC : 4'($urandom_range(0, 8));
      cyc(($urandom_range(0, 499) == 0) ? 1'b0 : 1'b1, rq, st);
    end

    repeat (3) @(negedge sysclk);
    chk("scoreboard_empty", 32'(q.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
